mem_verify: RTL and testbench

MEM_VERIFY -- requirements
Module: mem_verify

---
 rtl/mem_verify.sv | 137 +++++++++++++
 tb/tb_mem_verify.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_verify.sv
// mem_verify: reads back n bytes (saturated to 32) starting at m from the
// memory controller and counts bytes that differ from c[7:0].
// Ports: clk, reset (sync, active-high); start/m/c/n request inputs;
// finish pulse, return_val mismatch count, first_err_addr, err_valid;
// memory_controller_* master port (read-only, write_enable tied low).
// Optional first-error capture: define MEM_VERIFY_FIRST_ERR_EN.
module mem_verify (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] m,
  input  logic [31:0] c,
  input  logic [31:0] n,
  output logic        finish,
  output logic [31:0] return_val,
  output logic [31:0] first_err_addr,
  output logic        err_valid,
  output logic [31:0] memory_controller_address,
  output logic        memory_controller_write_enable,
  output logic [31:0] memory_controller_in,
  input  logic [31:0] memory_controller_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [7:0]  expect_byte;
  logic [5:0]  cnt;
  logic [5:0]  index;
  logic [5:0]  count;
  logic [1:0]  vld;
  logic        drain_cnt;
  logic        mismatch;
  logic [5:0]  cnt_in;
  logic        unused_bits;

`ifdef MEM_VERIFY_FIRST_ERR_EN
  logic [5:0]  cmp_idx;
  logic [31:0] ferr;
  assign first_err_addr = ferr;
`else
  assign first_err_addr = 32'd0;
`endif

  assign memory_controller_write_enable = 1'b0;
  assign memory_controller_in = 32'd0;
  assign unused_bits = ^{c[31:8], memory_controller_out[31:8]};

  // RAM is 32 bytes deep; longer requests saturate.
  assign cnt_in = (n > 32'd32) ? 6'd32 : n[5:0];

  // vld[1] marks data issued two edges ago, now on memory_controller_out.
  assign mismatch = vld[1] &&
                    (memory_controller_out[7:0] != expect_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= IDLE;
      base                      <= 32'd0;
      expect_byte               <= 8'd0;
      cnt                       <= 6'd0;
      index                     <= 6'd0;
      count                     <= 6'd0;
      vld                       <= 2'b00;
      drain_cnt                 <= 1'b0;
      finish                    <= 1'b0;
      return_val                <= 32'd0;
      err_valid                 <= 1'b0;
      memory_controller_address <= 32'd0;
`ifdef MEM_VERIFY_FIRST_ERR_EN
      cmp_idx                   <= 6'd0;
      ferr                      <= 32'd0;
`endif
    end else begin
      finish <= 1'b0;
      vld    <= {vld[0], 1'b0};

      if (mismatch) begin
        count <= count + 6'd1;
`ifdef MEM_VERIFY_FIRST_ERR_EN
        if (!err_valid) begin
          err_valid <= 1'b1;
          ferr      <= base + {26'd0, cmp_idx};
        end
`endif
      end
`ifdef MEM_VERIFY_FIRST_ERR_EN
      if (vld[1]) cmp_idx <= cmp_idx + 6'd1;
`endif

      unique case (state)
        IDLE: begin
          if (start) begin
            base        <= m;
            expect_byte <= c[7:0];
            cnt         <= cnt_in;
            index       <= 6'd0;
            count       <= 6'd0;
            err_valid   <= 1'b0;
`ifdef MEM_VERIFY_FIRST_ERR_EN
            cmp_idx     <= 6'd0;
            ferr        <= 32'd0;
`endif
            state <= (cnt_in == 6'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          memory_controller_address <= base + {26'd0, index};
          vld       <= {vld[0], 1'b1};
          index     <= index + 6'd1;
          drain_cnt <= 1'b0;
          if (index + 6'd1 == cnt) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          finish     <= 1'b1;
          return_val <= {26'd0, count};
`ifndef MEM_VERIFY_FIRST_ERR_EN
          err_valid  <= (count != 6'd0);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_verify.sv
// tb_mem_verify: randomized and directed checks of mem_verify against a
// byte-array memory model and a count/first-error reference model.
module tb_mem_verify;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] m, c, n;
  logic        finish;
  logic [31:0] return_val, first_err_addr;
  logic        err_valid;
  logic [31:0] addr;
  logic        we;
  logic [31:0] min;
  logic [31:0] mout;

  int n_checks = 0;
  int n_fail = 0;
  int we_bad = 0;

  logic [7:0] mem [bit [31:0]];

  always #5 clk = ~clk;

  mem_verify dut (
    .clk                            (clk),
    .reset                          (reset),
    .start                          (start),
    .m                              (m),
    .c                              (c),
    .n                              (n),
    .finish                         (finish),
    .return_val                     (return_val),
    .first_err_addr                 (first_err_addr),
    .err_valid                      (err_valid),
    .memory_controller_address      (addr),
    .memory_controller_write_enable (we),
    .memory_controller_in           (min),
    .memory_controller_out          (mout)
  );

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // One-cycle registered read; junk in upper bits must be ignored.
  always @(posedge clk) mout <= {24'hC3C3C3, rd(addr)};

  always @(negedge clk)
    if (we !== 1'b0 || min !== 32'd0) we_bad++;

  task automatic model(input logic [31:0] mm, input logic [31:0] cc,
                       input logic [31:0] nn, output int ret,
                       output logic [31:0] ferr, output int lat);
    int k;
    k = (nn > 32) ? 32 : int'(nn);
    ret = 0;
    ferr = 0;
    for (int i = 0; i < k; i++)
      if (rd(mm + i) != cc[7:0]) begin
        if (ret == 0) ferr = mm + i;
        ret++;
      end
`ifndef MEM_VERIFY_FIRST_ERR_EN
    ferr = 0;
`endif
    lat = (k == 0) ? 1 : k + 3;
  endtask

  // Poke: at that cycle count, pulse start with garbage request.
  task automatic do_run(input logic [31:0] mm, input logic [31:0] cc,
                        input logic [31:0] nn, input int poke,
                        output int ret, output int lat,
                        output logic [31:0] ferr, output logic ev);
    @(negedge clk);
    start = 1'b1; m = mm; c = cc; n = nn;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == poke) begin
        start = 1'b1; m = 32'h40; c = 32'hEE; n = 32'd3;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      if (finish === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    ret = int'(return_val);
    ferr = first_err_addr;
    ev = err_valid;
  endtask

  task automatic check_run(input string nm, input logic [31:0] mm,
                           input logic [31:0] cc, input logic [31:0] nn,
                           input int poke);
    int er, el, gr, gl;
    logic [31:0] ef, gf;
    logic gv;
    model(mm, cc, nn, er, ef, el);
    do_run(mm, cc, nn, poke, gr, gl, gf, gv);
    n_checks++;
    if (gl !== el) begin
      n_fail++;
      $display("FAIL %s latency got %0d want %0d", nm, gl, el);
    end
    n_checks++;
    if (gr !== er) begin
      n_fail++;
      $display("FAIL %s return_val got %0d want %0d", nm, gr, er);
    end
    n_checks++;
    if (gf !== ef) begin
      n_fail++;
      $display("FAIL %s first_err_addr got %h want %h", nm, gf, ef);
    end
    n_checks++;
    if (gv !== (er != 0)) begin
      n_fail++;
      $display("FAIL %s err_valid got %b want %b", nm, gv, er != 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; m = 0; c = 0; n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({finish, err_valid} !== 2'b00 || return_val !== 0 ||
        first_err_addr !== 0 || addr !== 0) begin
      n_fail++;
      $display("FAIL reset outputs fin=%b ev=%b rv=%h fe=%h a=%h want 0",
               finish, err_valid, return_val, first_err_addr, addr);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_match();
    for (int i = 0; i < 8; i++) mem[i] = 8'h5A;
    check_run("match", 0, 32'h5A, 8, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_pulse got %b want 0", finish);
    end
  endtask

  task automatic test_single_err();
    mem[3] = 8'h11;
    check_run("single_err", 0, 32'h5A, 8, 0);
    mem[3] = 8'h5A;
  endtask

  task automatic test_zero();
    logic [31:0] a0;
    a0 = addr;
    check_run("zero", 32'h10, 32'h5A, 0, 0);
    n_checks++;
    if (addr !== a0) begin
      n_fail++;
      $display("FAIL zero_addr got %h want %h", addr, a0);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 32; i++) mem[i] = 8'h77;
    mem[31] = 8'h01;
    for (int i = 32; i < 100; i++) mem[i] = 8'h02;
    check_run("saturate", 0, 32'h77, 100, 0);
    n_checks++;
    if (addr !== 32'd31) begin
      n_fail++;
      $display("FAIL saturate_last_addr got %h want %h", addr, 32'd31);
    end
  endtask

  task automatic test_reset_mid();
    int fins;
    for (int i = 0; i < 16; i++) mem[i] = 8'h33;
    @(negedge clk);
    start = 1'b1; m = 0; c = 32'h5A; n = 16;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({finish, err_valid} !== 2'b00 || return_val !== 0 ||
        first_err_addr !== 0 || addr !== 0) begin
      n_fail++;
      $display("FAIL reset_mid outputs fin=%b ev=%b rv=%h fe=%h a=%h want 0",
               finish, err_valid, return_val, first_err_addr, addr);
    end
    @(negedge clk) reset = 1'b0;
    fins = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (finish === 1'b1) fins++;
    end
    n_checks++;
    if (fins !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_finish got %0d pulses want 0", fins);
    end
    check_run("after_reset", 0, 32'h33, 16, 0);
  endtask

  task automatic test_ignore_start();
    for (int i = 0; i < 10; i++) mem[i] = 8'hC0 + 8'(i % 3);
    check_run("ignore_run", 0, 32'hC1, 10, 4);
    check_run("ignore_drain", 0, 32'hC0, 10, 11);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) mem[32'h20 + i] = 8'(i);
    check_run("b2b_a", 32'h20, 32'h03, 5, 0);
    check_run("b2b_b", 32'h20, 32'h00, 8, 0);
  endtask

  task automatic test_random();
    logic [31:0] mm, cc, nn;
    for (int t = 0; t < 10; t++) begin
      mm = (t == 9) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 200));
      cc = $urandom;
      nn = (t == 0) ? 32'd32 : 32'($urandom_range(0, 40));
      for (int i = 0; i < 40; i++)
        mem[mm + i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cc[7:0];
      check_run("random", mm, cc, nn, 0);
    end
  endtask

  task automatic test_write_enable();
    n_checks++;
    if (we_bad !== 0) begin
      n_fail++;
      $display("FAIL write_port got %0d bad cycles want 0", we_bad);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_single_err();
    test_zero();
    test_saturate();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_write_enable();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
